// File: rtl/multi_debounce.sv
// multi_debounce: N-channel push-button / switch debouncer.
// Each channel has a synchroniser chain, then a saturating up/down integrating
// counter, then a hysteresis comparator that produces the debounced level and
// one-cycle rise/fall pulses.
// Optional feature macro: LONG_PRESS_EN adds a per-channel long-press counter
// that drives hold_pulse; without it hold_pulse is tied to 0.
module multi_debounce #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 20,
    parameter int ON_THRESH   = 750000,
    parameter int OFF_THRESH  = 250000,
    parameter int HOLD_W      = 24,
    parameter int HOLD_CYCLES = 10000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] hold_pulse
);

    localparam longint CNT_MAX_L  = (longint'(1) << CNT_W) - 1;
    localparam longint HOLD_MAX_L = (longint'(1) << HOLD_W) - 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ON_T    = CNT_W'(ON_THRESH);
    localparam logic [CNT_W-1:0] OFF_T   = CNT_W'(OFF_THRESH);

    // Reject configurations that would break the hysteresis or wrap counters.
    if (CHANNELS < 1 || SYNC_STAGES < 2) begin : g_bad_shape
        $error("multi_debounce: CHANNELS must be >= 1 and SYNC_STAGES >= 2");
    end
    if (OFF_THRESH < 0 || OFF_THRESH >= ON_THRESH || longint'(ON_THRESH) > CNT_MAX_L) begin : g_bad_thresh
        $error("multi_debounce: need 0 <= OFF_THRESH < ON_THRESH <= 2^CNT_W-1");
    end
    // Checked even when the long-press logic is compiled out, so a
    // configuration stays valid when the feature is switched on later.
    if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) > HOLD_MAX_L) begin : g_bad_hold
        $error("multi_debounce: need 1 <= HOLD_CYCLES <= 2^HOLD_W-1");
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_reg;
        logic                   s_sync;
        logic [CNT_W-1:0]       cnt_reg;
        logic [CNT_W-1:0]       cnt_next;
        logic                   level_reg;
        logic                   level_next;
        logic                   rise_reg;
        logic                   rise_next;
        logic                   fall_reg;
        logic                   fall_next;

        assign s_sync = sync_reg[SYNC_STAGES-1];

        // Integrating counter: climbs while the synchronised input is high,
        // falls while it is low, and sticks at either end instead of wrapping.
        always_comb begin
            cnt_next = cnt_reg;
            if (s_sync && (cnt_reg != CNT_MAX)) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end else if (!s_sync && (cnt_reg != '0)) begin
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end

        // Hysteresis comparator on the registered count; edge pulses are
        // produced together with the level change so they align exactly.
        always_comb begin
            rise_next  = !level_reg && (cnt_reg >= ON_T);
            fall_next  = level_reg && (cnt_reg <= OFF_T);
            level_next = level_reg;
            if (rise_next) begin
                level_next = 1'b1;
            end else if (fall_next) begin
                level_next = 1'b0;
            end
        end

        // Channel state registers: synchroniser, counter, level and pulses.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_reg  <= '0;
                cnt_reg   <= '0;
                level_reg <= 1'b0;
                rise_reg  <= 1'b0;
                fall_reg  <= 1'b0;
            end else begin
                sync_reg  <= {sync_reg[SYNC_STAGES-2:0], btn[gi]};
                cnt_reg   <= cnt_next;
                level_reg <= level_next;
                rise_reg  <= rise_next;
                fall_reg  <= fall_next;
            end
        end

        assign level[gi]      = level_reg;
        assign rise_pulse[gi] = rise_reg;
        assign fall_pulse[gi] = fall_reg;

`ifdef LONG_PRESS_EN
        localparam logic [HOLD_W-1:0] HOLD_T = HOLD_W'(HOLD_CYCLES);

        logic [HOLD_W-1:0] hold_reg;
        logic [HOLD_W-1:0] hold_next;
        logic              hold_pulse_reg;
        logic              hold_pulse_next;

        // Long-press timer: counts debounced-high cycles, parks at the
        // target so the pulse fires once per press, clears when released.
        always_comb begin
            hold_next       = '0;
            hold_pulse_next = 1'b0;
            if (level_reg) begin
                hold_next = hold_reg;
                if (hold_reg != HOLD_T) begin
                    hold_next       = hold_reg + HOLD_W'(1);
                    hold_pulse_next = (hold_reg == (HOLD_T - HOLD_W'(1)));
                end
            end
        end

        // Long-press timer and pulse registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_reg       <= '0;
                hold_pulse_reg <= 1'b0;
            end else begin
                hold_reg       <= hold_next;
                hold_pulse_reg <= hold_pulse_next;
            end
        end

        assign hold_pulse[gi] = hold_pulse_reg;
`else
        assign hold_pulse[gi] = 1'b0;
`endif
    end

endmodule
